// File: rtl/rfphoenix_fetch_pkg.sv
// Shared types for the rfPhoenix instruction fetch controller.
// Holds the fetch buffer record, the fetch FSM states and the reset PC default.
package rfPhoenixPkg;

  localparam logic [31:0] RFP_RSTPC = 32'hFFFD0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [39:0] insn;
    logic        err;
  } InstructionFetchbuf;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rfphoenix_fetch_perf.sv
// Performance counters for the fetch controller: delivered instructions and
// cycles lost to downstream back-pressure. Both counters wrap at 2^32.
module rfphoenix_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Count delivered instructions and back-pressure stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/rfphoenix_fetch.sv
// rfPhoenix instruction fetch controller: owns the PC, issues one request at a
// time to the I-cache and writes each returned instruction into the decode FIFO.
// Optional macro RFPHOENIX_FETCH_PERF_EN enables the fetch/stall perf counters;
// without it both counter outputs are tied to zero.
module rfphoenix_fetch
  import rfPhoenixPkg::*;
#(
  parameter logic [31:0] RSTPC      = RFP_RSTPC,
  parameter int          INSN_BYTES = 5
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               almost_full,
  input  logic               redirect_v,
  input  logic [31:0]        redirect_pc,
  output logic               ic_req,
  output logic [31:0]        ic_adr,
  input  logic               ic_ack,
  input  logic [39:0]        ic_insn,
  input  logic               ic_err,
  output logic               wr,
  output InstructionFetchbuf ifbout,
  output logic [31:0]        pc,
  output logic               halted,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
);

  fetch_state_e       r_state;
  logic [31:0]        r_pc;
  logic               r_ic_req;
  logic [31:0]        r_ic_adr;
  logic               r_wr;
  InstructionFetchbuf r_ifbout;
  logic               r_halted;
  // Set when a redirect lands while a request is outstanding; the data that
  // eventually returns for the stale address must be discarded.
  logic               r_squash;

  // Fetch FSM: request issue, ack handling, redirect and fault halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RESET;
      r_pc     <= RSTPC;
      r_ic_req <= 1'b0;
      r_ic_adr <= '0;
      r_wr     <= 1'b0;
      r_ifbout <= '0;
      r_halted <= 1'b0;
      r_squash <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        ST_RESET: r_state <= ST_REQ;
        ST_REQ: begin
          if (redirect_v) begin
            r_pc <= redirect_pc;
          end else if (!almost_full) begin
            r_ic_req <= 1'b1;
            r_ic_adr <= r_pc;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ic_ack) begin
            r_ic_req <= 1'b0;
            if (r_squash || redirect_v) begin
              // Stale data: drop it and refetch from the (new) PC.
              r_squash <= 1'b0;
              if (redirect_v) r_pc <= redirect_pc;
              r_state <= ST_REQ;
            end else begin
              r_wr     <= 1'b1;
              r_ifbout <= '{pc: r_pc, insn: ic_insn, err: ic_err};
              if (ic_err) begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end else begin
                r_pc    <= r_pc + 32'(INSN_BYTES);
                r_state <= ST_REQ;
              end
            end
          end else if (redirect_v) begin
            r_pc     <= redirect_pc;
            r_squash <= 1'b1;
          end
        end
        ST_HALT: begin
          if (redirect_v) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_state  <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  assign ic_req = r_ic_req;
  assign ic_adr = r_ic_adr;
  assign wr     = r_wr;
  assign ifbout = r_ifbout;
  assign pc     = r_pc;
  assign halted = r_halted;

`ifdef RFPHOENIX_FETCH_PERF_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  assign w_fetch_inc = (r_state == ST_WAIT) && ic_ack && !r_squash && !redirect_v;
  assign w_stall_inc = (r_state == ST_REQ) && !redirect_v && almost_full;

  rfphoenix_fetch_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rfphoenix_fetch.sv
// Directed, table-driven bench for rfphoenix_fetch plus hand-written sequences
// for back-pressure, PC wrap and reset in the middle of a transaction.
module tb_rfphoenix_fetch;
  import rfPhoenixPkg::*;

`ifdef RFPHOENIX_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] R = 32'hFFFD0000;
  localparam logic [39:0] IA = 40'hA1A2A3A4A5;
  localparam logic [39:0] IB = 40'hB1B2B3B4B5;
  localparam logic [39:0] IC = 40'hC1C2C3C4C5;
  localparam logic [39:0] ID = 40'hD1D2D3D4D5;

  logic               rst, clk, almost_full, redirect_v, ic_ack, ic_err;
  logic [31:0]        redirect_pc;
  logic [39:0]        ic_insn;
  logic               ic_req, wr, halted;
  logic [31:0]        ic_adr, pc, fetch_cnt, stall_cnt;
  InstructionFetchbuf ifbout;

  int n_vec = 0;
  int n_err = 0;

  rfphoenix_fetch dut (
    .rst(rst), .clk(clk), .almost_full(almost_full), .redirect_v(redirect_v),
    .redirect_pc(redirect_pc), .ic_req(ic_req), .ic_adr(ic_adr), .ic_ack(ic_ack),
    .ic_insn(ic_insn), .ic_err(ic_err), .wr(wr), .ifbout(ifbout), .pc(pc),
    .halted(halted), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst, af, rv;
    logic [31:0]        rpc;
    logic               ack;
    logic [39:0]        insn;
    logic               err;
    logic               e_req;
    logic [31:0]        e_adr;
    logic               e_wr;
    InstructionFetchbuf e_ifb;
    logic [31:0]        e_pc;
    logic               e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic af, logic rv, logic [31:0] rpc,
                              logic ack, logic [39:0] insn, logic err,
                              logic ereq, logic [31:0] eadr, logic ewr,
                              logic [31:0] fpc, logic [39:0] fins, logic ferr,
                              logic [31:0] epc, logic eh);
    vec_t t;
    t.rst = r; t.af = af; t.rv = rv; t.rpc = rpc; t.ack = ack; t.insn = insn;
    t.err = err; t.e_req = ereq; t.e_adr = eadr; t.e_wr = ewr;
    t.e_ifb = '{pc: fpc, insn: fins, err: ferr};
    t.e_pc = epc; t.e_halt = eh;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; almost_full = 0; redirect_v = 0; redirect_pc = '0;
    ic_ack = 0; ic_insn = '0; ic_err = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;

    // Reset, three back-to-back fetches with a zero-wait cache
    tbl.push_back(mk(1,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          1,IA,0, 0,0,1,        R,IA,0,       R+5,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+5,0,      0,0,0,        R+5,0));
    tbl.push_back(mk(0,0,0,0,          1,IB,0, 0,0,1,        R+5,IB,0,     R+10,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+10,0,     0,0,0,        R+10,0));
    tbl.push_back(mk(0,0,0,0,          1,IC,0, 0,0,1,        R+10,IC,0,    R+15,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+15,0,     0,0,0,        R+15,0));
    // Redirect while waiting, ack three cycles later is squashed
    tbl.push_back(mk(0,0,1,32'h1000,   0,0,0,  1,R+15,0,     0,0,0,        32'h1000,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+15,0,     0,0,0,        32'h1000,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+15,0,     0,0,0,        32'h1000,0));
    tbl.push_back(mk(0,0,0,0,          1,ID,0, 0,0,0,        0,0,0,        32'h1000,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,32'h1000,0, 0,0,0,        32'h1000,0));
    // Redirect coincident with ack: redirect wins
    tbl.push_back(mk(0,0,1,32'h3000,   1,ID,0, 0,0,0,        0,0,0,        32'h3000,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,32'h3000,0, 0,0,0,        32'h3000,0));
    // Reset again, then a fault on the second fetch
    tbl.push_back(mk(1,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R,0,        0,0,0,        R,0));
    tbl.push_back(mk(0,0,0,0,          1,IA,0, 0,0,1,        R,IA,0,       R+5,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,R+5,0,      0,0,0,        R+5,0));
    tbl.push_back(mk(0,0,0,0,          1,IB,1, 0,0,1,        R+5,IB,1,     R+5,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R+5,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  0,0,0,        0,0,0,        R+5,1));
    tbl.push_back(mk(0,0,1,32'h2000,   0,0,0,  0,0,0,        0,0,0,        32'h2000,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,  1,32'h2000,0, 0,0,0,        32'h2000,0));
    tbl.push_back(mk(0,0,0,0,          1,IC,0, 0,0,1,        32'h2000,IC,0, 32'h2005,0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; almost_full = tbl[i].af; redirect_v = tbl[i].rv;
      redirect_pc = tbl[i].rpc; ic_ack = tbl[i].ack; ic_insn = tbl[i].insn;
      ic_err = tbl[i].err;
      step();
      n_vec++;
      if (ic_req !== tbl[i].e_req || wr !== tbl[i].e_wr || pc !== tbl[i].e_pc ||
          halted !== tbl[i].e_halt ||
          ((tbl[i].e_req || tbl[i].rst) && ic_adr !== tbl[i].e_adr) ||
          ((tbl[i].e_wr || tbl[i].rst) && ifbout !== tbl[i].e_ifb)) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b adr=%h wr=%b ifb=%h pc=%h halt=%b expected req=%b adr=%h wr=%b ifb=%h pc=%h halt=%b",
                 i, ic_req, ic_adr, wr, ifbout, pc, halted, tbl[i].e_req,
                 tbl[i].e_adr, tbl[i].e_wr, tbl[i].e_ifb, tbl[i].e_pc, tbl[i].e_halt);
      end
    end
    idle_in();

    // Three instructions delivered since the last reset (A, faulting B, C)
    chk("fetch_cnt_3", 128'(fetch_cnt), PERF ? 128'd3 : 128'd0);
    chk("stall_cnt_0", 128'(stall_cnt), 128'd0);

    // Back-pressure: ten cycles held off in ST_REQ
    almost_full = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_no_req", 128'(ic_req), 128'd0);
    end
    almost_full = 0;
    chk("stall_cnt_10", 128'(stall_cnt), PERF ? 128'd10 : 128'd0);
    step();
    chk("bp_release_req", 128'({ic_req, ic_adr}), 128'({1'b1, 32'h2005}));
    ic_ack = 1; ic_insn = ID;
    step();
    idle_in();
    chk("bp_deliver", 128'({wr, ifbout, pc}), 128'({1'b1, 32'h2005, ID, 1'b0, 32'h200A}));

    // PC wrap past 2^32
    redirect_v = 1; redirect_pc = 32'hFFFFFFFE;
    step();
    idle_in();
    step();
    chk("wrap_req", 128'({ic_req, ic_adr}), 128'({1'b1, 32'hFFFFFFFE}));
    ic_ack = 1; ic_insn = IA;
    step();
    idle_in();
    chk("wrap_pc", 128'({wr, ifbout.pc, pc}), 128'({1'b1, 32'hFFFFFFFE, 32'h00000003}));

    // Reset in the middle of ST_WAIT, then a late ack
    step();
    chk("mw_in_wait", 128'({ic_req, ic_adr}), 128'({1'b1, 32'h3}));
    rst = 1;
    step();
    chk("mw_reset_out", 128'({ic_req, ic_adr, wr, ifbout, pc, halted}),
        128'({1'b0, 32'h0, 1'b0, 73'h0, R, 1'b0}));
    chk("mw_reset_cnt", 128'({fetch_cnt, stall_cnt}), 128'd0);
    rst = 0; ic_ack = 1; ic_insn = IB;
    step();
    chk("mw_late_ack1", 128'({wr, ic_req, pc}), 128'({1'b0, 1'b0, R}));
    step();
    chk("mw_late_ack2", 128'({wr, ic_req, ic_adr, pc}), 128'({1'b0, 1'b1, R, R}));
    idle_in();
    step();
    chk("mw_fetch_cnt", 128'(fetch_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
